onchip_mem_loader: RTL and testbench
====================================

Name: onchip_mem_loader

Overview:
- Avalon-MM master that sits directly upstream of the 32-bit single-port on-chip RAM (13-bit word address, 4-lane byteenable, one-cycle read latency).
- Packs an incoming byte stream, such as a boot image from UART/SPI, little-endian into 32-bit words, writes them from BASE_ADDR upward, then reads the image back to verify a running checksum.
- Reports done, error and word count to the control logic.

Parameters:
ADDR_W, 13, word-address width of the RAM port
DEPTH, 6500, number of words in the RAM; last valid address is DEPTH-1
BASE_ADDR, 0, first word address written

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse that begins a load; ignored unless IDLE
byte_valid  in  1  byte_data valid
byte_data  in  8  stream byte
byte_last  in  1  qualifies the final byte of the image (sampled with byte_valid)
byte_ready  out  1  loader accepts a byte this cycle
mem_address  out  ADDR_W  RAM word address
mem_byteenable  out  4  RAM byte lanes
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write strobe
mem_writedata  out  32  RAM write data
mem_clken  out  1  RAM clock enable
mem_readdata  in  32  RAM read data, valid the cycle after the address is presented
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a load
error  out  1  sticky overflow/verify failure; cleared by the next accepted start
word_count  out  ADDR_W  words written in the current/last load
checksum  out  32  mod-2^32 sum of masked written words

Behaviour:
- Reset (async): state IDLE; all outputs 0, including mem_clken, byte_ready, error, word_count and checksum. mem_clken goes to 1 on the first clock after reset deassertion and stays 1.
- States: IDLE, FILL, WRITE, RD_ADDR, RD_DATA, DONE.
- IDLE
  - byte_ready=0.
  - On start: clear address (=BASE_ADDR), lane index, word_count, checksum, readback sum and error; go to FILL.
- FILL
  - byte_ready=1. A byte is accepted on byte_valid & byte_ready.
  - Lane k (0..3) goes to writedata[8k+7:8k]; set bit k of the byteenable; lane index increments.
  - After accepting lane 3, or any byte with byte_last=1, go to WRITE.
  - Lanes not filled are 0 in writedata.
- WRITE
  - Exactly one cycle: chipselect=1, write=1, driving the packed address, data and byteenable. byte_ready=0.
  - checksum += writedata; word_count++.
  - If the last byte has been seen: reset address to BASE_ADDR and go to RD_ADDR.
  - Else if the address just written equals DEPTH-1: set error and go to DONE (overflow; no further bytes accepted).
  - Else: increment address, lane index=0, go to FILL.
- Only the final word may have a partial byteenable, and it is always contiguous from lane 0: 0001, 0011 or 0111.
- RD_ADDR: chipselect=1, write=0, byteenable=1111; address presented. Go to RD_DATA.
- RD_DATA
  - Capture mem_readdata. For the final word, mask it with the stored final byteenable before use.
  - Add the result to the readback sum.
  - If this was word word_count-1: compare readback sum with checksum; on mismatch set error; go to DONE.
  - Otherwise increment address and go to RD_ADDR.
  - Verify costs 2 cycles per word (not pipelined).
- DONE: done=1 for exactly one cycle; go to IDLE. checksum, word_count and error hold until the next start.
- In all states other than WRITE and RD_ADDR: chipselect=0 and write=0.
- The memory write strobe is never asserted outside WRITE.
- start while busy: ignored, no effect.
- byte_valid while not FILL: not accepted, because byte_ready=0; the producer holds the byte.
- Reset mid-operation: returns to IDLE immediately. RAM contents are partial/undefined. No done pulse is issued.

Test Plan:
- Start, then bytes 11,22,33,44 (last on 44) → one write at addr 0, data 0x44332211, be 1111. After 2 verify cycles: done=1, error=0, word_count=1, checksum=0x44332211.
- 5 bytes 01..05 (last on 05) → writes (0, 0x04030201, 1111) and (1, 0x00000005, 0001). checksum=0x04030206, word_count=2, error=0.
- Same as previous, but the RAM model corrupts word 1 on readback to 0x00000105 → masked, so no error. Then corrupt word 0 → error=1 with done.
- DEPTH=4, feed 20 bytes without last → 4 writes (addresses 0..3), then done with error=1 and word_count=4. byte_ready stays 0 after the 16th byte.
- Random byte_valid gaps and a second start pulse mid-FILL → identical writes/checksum to the gap-free run; the start pulse is ignored.
- Assert reset after 6 bytes accepted → all outputs 0 asynchronously; a new start then loads a 4-byte image correctly with error=0.

Source files
------------

// File: rtl/onchip_mem_loader.sv
// Byte-stream loader for a 32-bit single-port on-chip RAM: packs bytes little-endian,
// writes them from BASE_ADDR upward, then reads the image back and verifies its checksum.
module onchip_mem_loader #(
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 6500,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count,
    output logic [31:0]       checksum
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    // Expand a byteenable into a 32-bit data mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [3:0]        final_be_q, final_be_d;
    logic              last_seen_q, last_seen_d;
    logic [ADDR_W-1:0] wc_q, wc_d;
    logic [31:0]       cksum_q, cksum_d;
    logic [31:0]       rbsum_q, rbsum_d;
    logic              error_q, error_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              byte_ready_q, byte_ready_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [3:0]        mbe_q, mbe_d;
    logic              clken_q;

    logic [ADDR_W-1:0] last_rd_addr_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       rd_sum_s;

    // Readback of the final word ignores lanes that were never written.
    always_comb begin
        last_rd_addr_s = BASE + wc_q - ONE;
        if (addr_q == last_rd_addr_s) begin
            rd_word_s = mem_readdata & be_mask(final_be_q);
        end else begin
            rd_word_s = mem_readdata;
        end
        rd_sum_s = rbsum_q + rd_word_s;
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        final_be_d  = final_be_q;
        last_seen_d = last_seen_q;
        wc_d        = wc_q;
        cksum_d     = cksum_q;
        rbsum_d     = rbsum_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = BASE;
                    lane_d      = 2'd0;
                    wdata_d     = 32'h0000_0000;
                    be_d        = 4'b0000;
                    last_seen_d = 1'b0;
                    wc_d        = '0;
                    cksum_d     = 32'h0000_0000;
                    rbsum_d     = 32'h0000_0000;
                    error_d     = 1'b0;
                    state_d     = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (byte_valid && byte_ready_q) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = byte_data;
                    be_d[lane_q] = 1'b1;
                    lane_d       = lane_q + 2'd1;
                    last_seen_d  = byte_last;
                    if ((lane_q == 2'd3) || byte_last) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WRITE: begin
                cksum_d = cksum_q + wdata_q;
                wc_d    = wc_q + ONE;
                if (last_seen_q) begin
                    addr_d     = BASE;
                    final_be_d = be_q;
                    state_d    = S_RD_ADDR;
                end else if (addr_q == LAST_ADDR) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ONE;
                    lane_d  = 2'd0;
                    wdata_d = 32'h0000_0000;
                    be_d    = 4'b0000;
                    state_d = S_FILL;
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rbsum_d = rd_sum_s;
                if (addr_q == last_rd_addr_s) begin
                    if (rd_sum_s != cksum_q) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ONE;
                    state_d = S_RD_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops clean.
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        byte_ready_d = (state_d == S_FILL);
        cs_d         = (state_d == S_WRITE) || (state_d == S_RD_ADDR);
        wr_d         = (state_d == S_WRITE);
        if (state_d == S_WRITE) begin
            mbe_d = be_d;
        end else if (state_d == S_RD_ADDR) begin
            mbe_d = 4'b1111;
        end else begin
            mbe_d = 4'b0000;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            lane_q       <= 2'd0;
            wdata_q      <= 32'h0000_0000;
            be_q         <= 4'b0000;
            final_be_q   <= 4'b0000;
            last_seen_q  <= 1'b0;
            wc_q         <= '0;
            cksum_q      <= 32'h0000_0000;
            rbsum_q      <= 32'h0000_0000;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            cs_q         <= 1'b0;
            wr_q         <= 1'b0;
            mbe_q        <= 4'b0000;
            clken_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            final_be_q   <= final_be_d;
            last_seen_q  <= last_seen_d;
            wc_q         <= wc_d;
            cksum_q      <= cksum_d;
            rbsum_q      <= rbsum_d;
            error_q      <= error_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            byte_ready_q <= byte_ready_d;
            cs_q         <= cs_d;
            wr_q         <= wr_d;
            mbe_q        <= mbe_d;
            clken_q      <= 1'b1;
        end
    end

    assign byte_ready     = byte_ready_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = mbe_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = clken_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = wc_q;
    assign checksum       = cksum_q;

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Scoreboard bench for onchip_mem_loader with a behavioural one-cycle-latency RAM model.
module tb_onchip_mem_loader;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_last = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] word_count;
    logic [31:0]   checksum;

    onchip_mem_loader #(.ADDR_W(AW), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .busy(busy), .done(done), .error(error),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
    typedef struct { logic err; logic [AW-1:0] wc; logic [31:0] ck; } done_t;

    wr_t   wq[$];
    done_t dq[$];
    wr_t   mw;
    done_t md;
    int    tests = 0;
    int    fails = 0;
    int    done_cnt = 0;

    // RAM model with optional readback corruption of one address
    logic [31:0]   ram [0:8191];
    logic          corrupt_on = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [31:0]   corrupt_val = 32'h0;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
            end else if (corrupt_on && mem_address == corrupt_addr) begin
                mem_readdata <= corrupt_val;
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and completions when the DUT presents them.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect && mem_write) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected none", mem_address, mem_writedata);
                end else begin
                    mw = wq.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(mw.a));
                    chk("wr_data", mem_writedata, mw.d);
                    chk("wr_be", 32'(mem_byteenable), 32'(mw.be));
                end
            end
            if (done) begin
                done_cnt++;
                if (dq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    md = dq.pop_front();
                    chk("done_error", 32'(error), 32'(md.err));
                    chk("done_word_count", 32'(word_count), 32'(md.wc));
                    chk("done_checksum", checksum, md.ck);
                end
            end
        end
    end

    task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t w;
        w.a = a; w.d = d; w.be = be;
        wq.push_back(w);
    endtask

    task automatic exp_done(input logic e, input logic [AW-1:0] wc, input logic [31:0] ck);
        done_t x;
        x.err = e; x.wc = wc; x.ck = ck;
        dq.push_back(x);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, input logic l, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = b; byte_last = l;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL byte_accept: got byte_ready=0 for 100 cycles, expected 1");
        end else begin
            @(posedge clk);
        end
        #1 byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c0, n;
        c0 = done_cnt; n = 0;
        while (done_cnt == c0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt == c0) begin
            tests++; fails++;
            $display("FAIL %s: got no done within 200 cycles, expected done", name);
        end
    endtask

    task automatic load5(input int gap, input logic mid_start);
        exp_wr(13'd0, 32'h04030201, 4'b1111);
        exp_wr(13'd1, 32'h00000005, 4'b0001);
        pulse_start();
        put_byte(8'h01, 1'b0, gap);
        put_byte(8'h02, 1'b0, 0);
        if (mid_start) pulse_start();
        put_byte(8'h03, 1'b0, gap);
        put_byte(8'h04, 1'b0, gap + 1);
        put_byte(8'h05, 1'b1, gap);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_cs_we"}, 32'({mem_chipselect, mem_write}), 32'd0);
        chk({tag, "_clken"}, 32'(mem_clken), 32'd0);
        chk({tag, "_done_error"}, 32'({done, error}), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_checksum"}, checksum, 32'd0);
        chk({tag, "_addr_be"}, 32'({mem_address, mem_byteenable}), 32'd0);
        chk({tag, "_writedata"}, mem_writedata, 32'd0);
    endtask

    initial begin
        int rdy_hi, c0;
        #3;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("clken_after_reset", 32'(mem_clken), 32'd1);

        // 4-byte image
        exp_wr(13'd0, 32'h44332211, 4'b1111);
        exp_done(1'b0, 13'd1, 32'h44332211);
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        put_byte(8'h11, 1'b0, 0);
        put_byte(8'h22, 1'b0, 0);
        put_byte(8'h33, 1'b0, 0);
        put_byte(8'h44, 1'b1, 0);
        wait_done("t1_done");

        // 5-byte image with partial final word
        exp_done(1'b0, 13'd2, 32'h04030206);
        load5(0, 1'b0);
        wait_done("t2_done");

        // unused lanes of the final word corrupted: masked, no error
        corrupt_on = 1'b1; corrupt_addr = 13'd1; corrupt_val = 32'h00000105;
        exp_done(1'b0, 13'd2, 32'h04030206);
        load5(0, 1'b0);
        wait_done("t3a_done");

        // full word corrupted: verify failure
        corrupt_addr = 13'd0; corrupt_val = 32'h04030200;
        exp_done(1'b1, 13'd2, 32'h04030206);
        load5(0, 1'b0);
        wait_done("t3b_done");
        corrupt_on = 1'b0;

        // overflow with DEPTH=4: 16 bytes fill the RAM, more are refused
        for (int w = 0; w < 4; w++)
            exp_wr(AW'(w), {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 4'b1111);
        exp_done(1'b1, 13'd4, 32'h2824201C);
        pulse_start();
        for (int i = 1; i <= 16; i++) put_byte(8'(i), 1'b0, 0);
        c0 = done_cnt; rdy_hi = 0;
        byte_valid = 1'b1; byte_data = 8'h11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (byte_ready) rdy_hi++;
        end
        byte_valid = 1'b0;
        chk("overflow_ready_low", 32'(rdy_hi), 32'd0);
        chk("overflow_done_seen", 32'(done_cnt - c0), 32'd1);

        // gaps and a start pulse mid-FILL give the same result
        exp_done(1'b0, 13'd2, 32'h04030206);
        load5(2, 1'b1);
        wait_done("t5_done");

        // reset mid-load, then a clean reload
        exp_wr(13'd0, 32'hA4A3A2A1, 4'b1111);
        pulse_start();
        for (int i = 1; i <= 6; i++) put_byte(8'hA0 + 8'(i), 1'b0, 0);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk); reset = 1'b0;
        exp_wr(13'd0, 32'hEFBEADDE, 4'b1111);
        exp_done(1'b0, 13'd1, 32'hEFBEADDE);
        pulse_start();
        put_byte(8'hDE, 1'b0, 0);
        put_byte(8'hAD, 1'b0, 1);
        put_byte(8'hBE, 1'b0, 0);
        put_byte(8'hEF, 1'b1, 0);
        wait_done("t6_done");

        repeat (5) @(negedge clk);
        chk("write_queue_empty", 32'(wq.size()), 32'd0);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
